vram_arbiter: RTL and testbench

//  Four-master arbiter directly upstream of the VRAM block. Serializes requests from host CPU

---
 rtl/vram_arbiter_if.sv | 43 ++++
 rtl/vram_arbiter.sv | 138 +++++++++++++
 tb/tb_vram_arbiter.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/vram_arbiter_if.sv
// Request/response bundle between the four VRAM masters, the VRAM word port and vram_arbiter.
// master = requesters plus VRAM side (drives reqs and bus_rddata); slave = the arbiter.
interface vram_arbiter_if #(parameter int ADDR_W = 15);
  logic              host_req;
  logic              host_write;
  logic [ADDR_W+1:0] host_addr;
  logic [7:0]        host_wrdata;
  logic              host_ack;
  logic [7:0]        host_rddata;
  logic              host_rvalid;

  logic              l0_req, l1_req, spr_req;
  logic [ADDR_W-1:0] l0_addr, l1_addr, spr_addr;
  logic              l0_ack, l1_ack, spr_ack;
  logic [31:0]       l0_rddata, l1_rddata, spr_rddata;
  logic              l0_rvalid, l1_rvalid, spr_rvalid;

  logic [ADDR_W-1:0] bus_addr;
  logic [31:0]       bus_wrdata;
  logic [3:0]        bus_wrbytesel;
  logic              bus_write;
  logic [31:0]       bus_rddata;

  modport master (
    output host_req, host_write, host_addr, host_wrdata,
    input  host_ack, host_rddata, host_rvalid,
    output l0_req, l1_req, spr_req, l0_addr, l1_addr, spr_addr,
    input  l0_ack, l1_ack, spr_ack, l0_rddata, l1_rddata, spr_rddata,
    input  l0_rvalid, l1_rvalid, spr_rvalid,
    input  bus_addr, bus_wrdata, bus_wrbytesel, bus_write,
    output bus_rddata
  );

  modport slave (
    input  host_req, host_write, host_addr, host_wrdata,
    output host_ack, host_rddata, host_rvalid,
    input  l0_req, l1_req, spr_req, l0_addr, l1_addr, spr_addr,
    output l0_ack, l1_ack, spr_ack, l0_rddata, l1_rddata, spr_rddata,
    output l0_rvalid, l1_rvalid, spr_rvalid,
    output bus_addr, bus_wrdata, bus_wrbytesel, bus_write,
    input  bus_rddata
  );
endinterface

// File: rtl/vram_arbiter.sv
// vram_arbiter: serializes host + three renderer ports onto the VRAM word port and routes reads back.
// Define VRAM_ARB_HOST_PRIORITY_EN to give the host fixed priority; renderers then round-robin.
module vram_arbiter #(
  parameter int         ADDR_W  = 15,
  parameter logic [1:0] RR_INIT = 2'd0
) (
  input logic           clk,
  input logic           rst_n,
  vram_arbiter_if.slave arb
);
  localparam int STAGES = 1;
  localparam logic [1:0] P_HOST = 2'd0, P_L0 = 2'd1, P_L1 = 2'd2, P_SPR = 2'd3;

  logic [3:0]              req_v, elig, rr_elig, ack_q, rvalid_q;
  logic [1:0]              rr_ptr, win, idx;
  logic                    found;
  logic [ADDR_W-1:0]       nxt_addr, addr_q;
  logic [31:0]             nxt_wrdata, wrdata_q;
  logic [3:0]              nxt_sel, sel_q;
  logic                    nxt_write, write_q;
  // Read tag {port, byte lane} travels alongside vld_pipe until the VRAM data is back.
  logic [STAGES:0]         vld_pipe;
  logic [STAGES:0][3:0]    tag_pipe;
  logic [1:0]              cap_port, cap_lane;
  logic [7:0]              host_rd_q;
  logic [31:0]             l0_rd_q, l1_rd_q, spr_rd_q;

  assign req_v = {arb.spr_req, arb.l1_req, arb.l0_req, arb.host_req};
  assign elig  = req_v & ~ack_q;

  always_comb begin
`ifdef VRAM_ARB_HOST_PRIORITY_EN
    rr_elig = {elig[3:1], 1'b0};
`else
    rr_elig = elig;
`endif
    found = 1'b0;
    win   = 2'd0;
    idx   = 2'd0;
    for (int i = 0; i < 4; i++) begin
      idx = rr_ptr + 2'(i);
      if (!found && rr_elig[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
`ifdef VRAM_ARB_HOST_PRIORITY_EN
    if (elig[P_HOST]) begin
      found = 1'b1;
      win   = P_HOST;
    end
`endif
  end

  always_comb begin
    nxt_addr   = arb.host_addr[ADDR_W+1:2];
    nxt_wrdata = {4{arb.host_wrdata}};
    nxt_write  = 1'b0;
    nxt_sel    = 4'b0000;
    case (win)
      P_HOST: begin
        nxt_write = arb.host_write;
        nxt_sel   = arb.host_write ? (4'b0001 << arb.host_addr[1:0]) : 4'b0000;
      end
      P_L0:    nxt_addr = arb.l0_addr;
      P_L1:    nxt_addr = arb.l1_addr;
      default: nxt_addr = arb.spr_addr;
    endcase
  end

  assign cap_port = tag_pipe[STAGES][3:2];
  assign cap_lane = tag_pipe[STAGES][1:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr    <= RR_INIT;
      ack_q     <= '0;
      rvalid_q  <= '0;
      addr_q    <= '0;
      wrdata_q  <= '0;
      sel_q     <= '0;
      write_q   <= 1'b0;
      vld_pipe  <= '0;
      tag_pipe  <= '0;
      host_rd_q <= '0;
      l0_rd_q   <= '0;
      l1_rd_q   <= '0;
      spr_rd_q  <= '0;
    end else begin
      ack_q    <= '0;
      rvalid_q <= '0;
      write_q  <= 1'b0;
      sel_q    <= 4'b0000;
      vld_pipe <= {vld_pipe[STAGES-1:0], 1'b0};
      tag_pipe <= {tag_pipe[STAGES-1:0], 4'h0};
      if (found) begin
        ack_q[win]  <= 1'b1;
        addr_q      <= nxt_addr;
        wrdata_q    <= nxt_wrdata;
        sel_q       <= nxt_sel;
        write_q     <= nxt_write;
        vld_pipe[0] <= !nxt_write;
        tag_pipe[0] <= {win, arb.host_addr[1:0]};
`ifdef VRAM_ARB_HOST_PRIORITY_EN
        if (win != P_HOST) rr_ptr <= win + 2'd1;
`else
        rr_ptr <= win + 2'd1;
`endif
      end
      if (vld_pipe[STAGES]) begin
        rvalid_q[cap_port] <= 1'b1;
        case (cap_port)
          P_HOST:  host_rd_q <= arb.bus_rddata[8*cap_lane +: 8];
          P_L0:    l0_rd_q   <= arb.bus_rddata;
          P_L1:    l1_rd_q   <= arb.bus_rddata;
          default: spr_rd_q  <= arb.bus_rddata;
        endcase
      end
    end
  end

  assign arb.host_ack      = ack_q[P_HOST];
  assign arb.l0_ack        = ack_q[P_L0];
  assign arb.l1_ack        = ack_q[P_L1];
  assign arb.spr_ack       = ack_q[P_SPR];
  assign arb.host_rvalid   = rvalid_q[P_HOST];
  assign arb.l0_rvalid     = rvalid_q[P_L0];
  assign arb.l1_rvalid     = rvalid_q[P_L1];
  assign arb.spr_rvalid    = rvalid_q[P_SPR];
  assign arb.host_rddata   = host_rd_q;
  assign arb.l0_rddata     = l0_rd_q;
  assign arb.l1_rddata     = l1_rd_q;
  assign arb.spr_rddata    = spr_rd_q;
  assign arb.bus_addr      = addr_q;
  assign arb.bus_wrdata    = wrdata_q;
  assign arb.bus_wrbytesel = sel_q;
  assign arb.bus_write     = write_q;
endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a 1-cycle registered VRAM word model.
module tb_vram_arbiter;
  localparam int ADDR_W = 15;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  logic [31:0] mem [0:63];
  logic        any_out;
  int          n_host, n_l0, n_l1, n_spr, n_bad;

  vram_arbiter_if #(.ADDR_W(ADDR_W)) vi ();
  vram_arbiter #(.ADDR_W(ADDR_W), .RR_INIT(2'd0)) dut (.clk(clk), .rst_n(rst_n), .arb(vi));

  always #5 clk = ~clk;

  // VRAM: byte-enabled write, registered read; preset contents while in reset.
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 64; i++) mem[i] <= {8'(i), 8'hC0, 8'(i), 8'h3C};
      vi.bus_rddata <= 32'h0;
    end else begin
      for (int b = 0; b < 4; b++)
        if (vi.bus_write && vi.bus_wrbytesel[b]) mem[vi.bus_addr[5:0]][8*b +: 8] <= vi.bus_wrdata[8*b +: 8];
      vi.bus_rddata <= mem[vi.bus_addr[5:0]];
    end
  end

  assign any_out = |{vi.host_ack, vi.host_rddata, vi.host_rvalid,
                     vi.l0_ack, vi.l1_ack, vi.spr_ack,
                     vi.l0_rddata, vi.l1_rddata, vi.spr_rddata,
                     vi.l0_rvalid, vi.l1_rvalid, vi.spr_rvalid,
                     vi.bus_addr, vi.bus_wrdata, vi.bus_wrbytesel, vi.bus_write};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n          = 1'b0;
    vi.host_req    = 1'b1;
    vi.host_write  = 1'b0;
    vi.host_addr   = '0;
    vi.host_wrdata = 8'h00;
    vi.l0_req      = 1'b1;
    vi.l1_req      = 1'b1;
    vi.spr_req     = 1'b1;
    vi.l0_addr     = '0;
    vi.l1_addr     = '0;
    vi.spr_addr    = '0;

    // 1: reset with every request high, first grant goes to RR_INIT (host)
    tick(); tick();
    chk("reset_outputs_zero", 64'(any_out), 64'd0);
    rst_n = 1'b1;
    tick();
    chk("first_grant_host", 64'({vi.spr_ack, vi.l1_ack, vi.l0_ack, vi.host_ack}), 64'b0001);
    vi.host_req = 1'b0; vi.l0_req = 1'b0; vi.l1_req = 1'b0; vi.spr_req = 1'b0;
    tick(); tick(); tick(); tick();

    // 2: host byte write 0xA5 to byte address 6
    vi.host_req = 1'b1; vi.host_write = 1'b1; vi.host_addr = 17'h00006; vi.host_wrdata = 8'hA5;
    tick();
    chk("wr_ack", 64'(vi.host_ack), 64'd1);
    chk("wr_bus_addr", 64'(vi.bus_addr), 64'h1);
    chk("wr_bus_wrdata", 64'(vi.bus_wrdata), 64'hA5A5A5A5);
    chk("wr_bytesel", 64'(vi.bus_wrbytesel), 64'b0100);
    chk("wr_bus_write", 64'(vi.bus_write), 64'd1);
    vi.host_req = 1'b0; vi.host_write = 1'b0;
    tick();
    chk("idle_addr_hold", 64'(vi.bus_addr), 64'h1);
    chk("idle_no_write", 64'({vi.bus_write, vi.bus_wrbytesel}), 64'd0);
    chk("idle_no_ack", 64'(vi.host_ack), 64'd0);
    tick();
    chk("wr_no_rvalid", 64'(vi.host_rvalid), 64'd0);
    tick(); tick();

    // 3: host read of the same byte returns in cycle 3
    vi.host_req = 1'b1; vi.host_addr = 17'h00006;
    tick();
    chk("rd_ack", 64'(vi.host_ack), 64'd1);
    chk("rd_no_write", 64'({vi.bus_write, vi.bus_wrbytesel}), 64'd0);
    vi.host_req = 1'b0;
    tick();
    chk("rd_c2_no_rvalid", 64'(vi.host_rvalid), 64'd0);
    tick();
    chk("rd_c3_rvalid", 64'(vi.host_rvalid), 64'd1);
    chk("rd_c3_data", 64'(vi.host_rddata), 64'hA5);
    tick();
    chk("rd_rvalid_pulse", 64'(vi.host_rvalid), 64'd0);
    chk("rd_data_hold", 64'(vi.host_rddata), 64'hA5);
    tick();

    // 4: three renderer reads issue back to back, data returns in grant order
    vi.l0_addr = 15'h0010; vi.l1_addr = 15'h0020; vi.spr_addr = 15'h0030;
    vi.l0_req = 1'b1; vi.l1_req = 1'b1; vi.spr_req = 1'b1;
    tick();
    chk("r_c1_acks", 64'({vi.spr_ack, vi.l1_ack, vi.l0_ack, vi.host_ack}), 64'b0010);
    chk("r_c1_addr", 64'(vi.bus_addr), 64'h10);
    vi.l0_req = 1'b0;
    tick();
    chk("r_c2_acks", 64'({vi.spr_ack, vi.l1_ack, vi.l0_ack, vi.host_ack}), 64'b0100);
    chk("r_c2_addr", 64'(vi.bus_addr), 64'h20);
    vi.l1_req = 1'b0;
    tick();
    chk("r_c3_acks", 64'({vi.spr_ack, vi.l1_ack, vi.l0_ack, vi.host_ack}), 64'b1000);
    chk("r_c3_addr", 64'(vi.bus_addr), 64'h30);
    chk("r_c3_rvalids", 64'({vi.spr_rvalid, vi.l1_rvalid, vi.l0_rvalid}), 64'b001);
    chk("r_c3_l0_data", 64'(vi.l0_rddata), 64'h10C0103C);
    vi.spr_req = 1'b0;
    tick();
    chk("r_c4_rvalids", 64'({vi.spr_rvalid, vi.l1_rvalid, vi.l0_rvalid}), 64'b010);
    chk("r_c4_l1_data", 64'(vi.l1_rddata), 64'h20C0203C);
    tick();
    chk("r_c5_rvalids", 64'({vi.spr_rvalid, vi.l1_rvalid, vi.l0_rvalid}), 64'b100);
    chk("r_c5_spr_data", 64'(vi.spr_rddata), 64'h30C0303C);
    tick(); tick();

    // 5: all four ports held high for 8 grant cycles
    n_host = 0; n_l0 = 0; n_l1 = 0; n_spr = 0; n_bad = 0;
    vi.host_req = 1'b1; vi.host_addr = 17'h00040;
    vi.l0_req = 1'b1; vi.l1_req = 1'b1; vi.spr_req = 1'b1;
    for (int c = 0; c < 8; c++) begin
      tick();
      n_host += int'(vi.host_ack);
      n_l0   += int'(vi.l0_ack);
      n_l1   += int'(vi.l1_ack);
      n_spr  += int'(vi.spr_ack);
      if ($countones({vi.spr_ack, vi.l1_ack, vi.l0_ack, vi.host_ack}) != 1) n_bad++;
    end
    vi.host_req = 1'b0; vi.l0_req = 1'b0; vi.l1_req = 1'b0; vi.spr_req = 1'b0;
    chk("all_one_grant_per_cycle", 64'(n_bad), 64'd0);
`ifdef VRAM_ARB_HOST_PRIORITY_EN
    chk("all_host_grants", 64'(n_host), 64'd4);
    chk("all_renderer_grants", 64'(n_l0 + n_l1 + n_spr), 64'd4);
`else
    chk("all_host_grants", 64'(n_host), 64'd2);
    chk("all_l0_grants", 64'(n_l0), 64'd2);
    chk("all_l1_grants", 64'(n_l1), 64'd2);
    chk("all_spr_grants", 64'(n_spr), 64'd2);
`endif
    tick(); tick(); tick(); tick();

    // 6: reset lands while a read is in flight
    vi.l0_addr = 15'h0011; vi.l0_req = 1'b1;
    tick();
    chk("rst6_ack", 64'(vi.l0_ack), 64'd1);
    vi.l0_req = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    chk("rst6_outputs_zero", 64'(any_out), 64'd0);
    chk("rst6_no_rvalid", 64'(vi.l0_rvalid), 64'd0);
    rst_n = 1'b1;
    vi.host_req = 1'b1; vi.l1_req = 1'b1;
    tick();
    chk("rst6_ptr_reinit", 64'({vi.spr_ack, vi.l1_ack, vi.l0_ack, vi.host_ack}), 64'b0001);
    chk("rst6_no_l0_rvalid", 64'(vi.l0_rvalid), 64'd0);
    vi.host_req = 1'b0; vi.l1_req = 1'b0;
    tick(); tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
